// File: rtl/scaler_line_reader.sv
// Read-side controller for the scaler line RAM: walks one source line at a fixed-point
// step and streams nearest-neighbour pixels. Define SCALER_LINE_READER_OUTREG_EN for a RAM with output register (LAT=2).
module scaler_line_reader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int STEP_FRAC  = 8
) (
    input  logic                   rd_clk,
    input  logic                   rd_rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [ADDR_WIDTH:0]    src_len,
    input  logic [ADDR_WIDTH:0]    out_len,
    input  logic [STEP_FRAC+3:0]   step,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  ram_rd_addr,
    output logic                   ram_rd_en,
    input  logic [DATA_WIDTH-1:0]  ram_rd_data,
    output logic [DATA_WIDTH-1:0]  pix_data,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic                   pix_last
);

`ifdef SCALER_LINE_READER_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = LAT + 1;
    localparam int ACC_W = ADDR_WIDTH + STEP_FRAC + 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   base_reg;
    logic [ADDR_WIDTH:0]     src_len_reg;
    logic [ADDR_WIDTH:0]     out_len_reg;
    logic [ADDR_WIDTH:0]     issued_reg;
    logic [STEP_FRAC+3:0]    step_reg;
    logic [ACC_W-1:0]        acc_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic [ADDR_WIDTH-1:0]   rd_addr_reg;

    // Stage 0 is the read strobe itself; stage LAT lines up with ram_rd_data.
    logic [LAT:0]            pipe_v_reg;
    logic [LAT:0]            pipe_l_reg;

    logic [DATA_WIDTH-1:0]   fifo_data_reg [DEPTH];
    logic                    fifo_last_reg [DEPTH];
    logic [PW-1:0]           rd_ptr_reg;
    logic [PW-1:0]           wr_ptr_reg;
    logic [CW-1:0]           fifo_cnt_reg;

    logic                    fifo_empty;
    logic                    ret_v;
    logic                    ret_l;
    logic                    beat;
    logic                    push;
    logic                    pop;
    logic [CW:0]             in_flight;
    logic [CW:0]             occupancy;
    logic                    credit_ok;
    logic [ADDR_WIDTH:0]     idx_raw;
    logic [ADDR_WIDTH:0]     idx_max;
    logic [ADDR_WIDTH-1:0]   idx_sat;
    logic [ACC_W:0]          acc_sum;
    logic [ACC_W-1:0]        acc_next;
    logic                    issue;
    logic                    issue_last;
    logic [ADDR_WIDTH-1:0]   issue_addr;

    assign fifo_empty = (fifo_cnt_reg == '0);
    assign ret_v      = pipe_v_reg[LAT];
    assign ret_l      = pipe_l_reg[LAT];
    assign beat       = pix_valid && pix_ready;
    // Returning data bypasses an empty FIFO when downstream can take it directly.
    assign push       = ret_v && !(fifo_empty && pix_ready);
    assign pop        = !fifo_empty && pix_ready;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i <= LAT; i++) begin
            in_flight = in_flight + {{CW{1'b0}}, pipe_v_reg[i]};
        end
    end

    // A beat leaving this cycle frees its slot in time for the next issued read.
    assign occupancy = in_flight + {1'b0, fifo_cnt_reg} - {{CW{1'b0}}, beat};
    assign credit_ok = (occupancy < (CW+1)'(DEPTH));

    assign idx_raw  = acc_reg[ACC_W-1:STEP_FRAC];
    assign idx_max  = src_len_reg - ONE;
    assign idx_sat  = (idx_raw > idx_max) ? idx_max[ADDR_WIDTH-1:0] : idx_raw[ADDR_WIDTH-1:0];
    assign acc_sum  = {1'b0, acc_reg} + (ACC_W+1)'(step_reg);
    assign acc_next = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];

    always_comb begin
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_addr = rd_addr_reg;
        if (state_reg == IDLE && start && out_len != '0) begin
            issue      = 1'b1;
            issue_last = (out_len == ONE);
            issue_addr = base_addr;
        end else if (state_reg == RUN && issued_reg != out_len_reg && credit_ok) begin
            issue      = 1'b1;
            issue_last = (issued_reg == out_len_reg - ONE);
            issue_addr = base_reg + idx_sat;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_reg   <= IDLE;
            base_reg    <= '0;
            src_len_reg <= '0;
            out_len_reg <= '0;
            issued_reg  <= '0;
            step_reg    <= '0;
            acc_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            rd_addr_reg <= '0;
            pipe_v_reg  <= '0;
            pipe_l_reg  <= '0;
        end else begin
            done_reg   <= 1'b0;
            pipe_v_reg <= {pipe_v_reg[LAT-1:0], issue};
            pipe_l_reg <= {pipe_l_reg[LAT-1:0], issue_last};
            if (issue) begin
                rd_addr_reg <= issue_addr;
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        base_reg    <= base_addr;
                        src_len_reg <= src_len;
                        out_len_reg <= out_len;
                        step_reg    <= step;
                        busy_reg    <= 1'b1;
                        if (out_len == '0) begin
                            acc_reg    <= '0;
                            issued_reg <= '0;
                            state_reg  <= FIN;
                        end else begin
                            // The first read (index 0) goes out with the start itself.
                            acc_reg    <= ACC_W'(step);
                            issued_reg <= ONE;
                            state_reg  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        acc_reg    <= acc_next;
                        issued_reg <= issued_reg + ONE;
                    end
                    if (issued_reg == out_len_reg) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (beat && pix_last) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else if (in_flight == '0 && fifo_empty) begin
                        state_reg <= FIN;
                    end
                end
                FIN: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH-1)) ? '0 : wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH-1)) ? '0 : rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + CW'(1);
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - CW'(1);
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
    end

    always_ff @(posedge rd_clk) begin
        if (push) begin
            fifo_data_reg[wr_ptr_reg] <= ram_rd_data;
            fifo_last_reg[wr_ptr_reg] <= ret_l;
        end
    end

    always_comb begin
        pix_valid = !fifo_empty || ret_v;
        pix_data  = '0;
        pix_last  = 1'b0;
        if (!fifo_empty) begin
            pix_data = fifo_data_reg[rd_ptr_reg];
            pix_last = fifo_last_reg[rd_ptr_reg];
        end else if (ret_v) begin
            pix_data = ram_rd_data;
            pix_last = ret_l;
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign ram_rd_en   = pipe_v_reg[0];
    assign ram_rd_addr = rd_addr_reg;

endmodule

// File: tb/tb_scaler_line_reader.sv
// Directed bench for scaler_line_reader: table of line commands plus reset/edge sequences,
// against a behavioural line RAM holding RAM[a] = 255 - (a mod 256).
module tb_scaler_line_reader;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int SF = 8;
`ifdef SCALER_LINE_READER_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = LAT + 1;
    localparam int NV = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   src_len = 13'd1;
    logic [AW:0]   out_len = '0;
    logic [SF+3:0] step = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_rd_addr;
    logic          ram_rd_en;
    logic [DW-1:0] ram_rd_data;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_ready = 1'b1;
    logic          pix_last;

    scaler_line_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STEP_FRAC(SF)) dut (
        .rd_clk(clk), .rd_rst(rst), .start(start), .base_addr(base_addr),
        .src_len(src_len), .out_len(out_len), .step(step), .busy(busy), .done(done),
        .ram_rd_addr(ram_rd_addr), .ram_rd_en(ram_rd_en), .ram_rd_data(ram_rd_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [4096];
    logic [DW-1:0] q1 = '0;
    logic [DW-1:0] q2 = '0;
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'(255 - (i % 256));
    end
    always @(posedge clk) begin
        if (ram_rd_en) q1 <= ram[ram_rd_addr];
        q2 <= q1;
    end
    assign ram_rd_data = (LAT == 2) ? q2 : q1;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    int start_cyc, first_en_cyc, first_valid_cyc, first_beat_cyc, final_beat_cyc, done_cyc;
    int done_cnt, valid_cnt, issues, beats, last_cnt, last_idx, stall_err, credit_err;
    int busy_at_en, busy_at_done;
    int addr_q[$];
    int data_q[$];
    logic prev_stall;
    logic [DW-1:0] prev_data;
    logic prev_last;

    task automatic clear_mon();
        start_cyc = -1; first_en_cyc = -1; first_valid_cyc = -1; first_beat_cyc = -1;
        final_beat_cyc = -1; done_cyc = -1; done_cnt = 0; valid_cnt = 0; issues = 0;
        beats = 0; last_cnt = 0; last_idx = -1; stall_err = 0; credit_err = 0;
        busy_at_en = -1; busy_at_done = -1; prev_stall = 1'b0;
        addr_q.delete(); data_q.delete();
    endtask

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (start && start_cyc < 0) start_cyc = cyc;
        if (ram_rd_en) begin
            if (first_en_cyc < 0) begin first_en_cyc = cyc; busy_at_en = int'(busy); end
            addr_q.push_back(int'(ram_rd_addr));
            issues = issues + 1;
        end
        if (issues - beats > DEPTH) credit_err = credit_err + 1;
        if (pix_valid) begin
            valid_cnt = valid_cnt + 1;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (prev_stall && (!pix_valid || pix_data !== prev_data || pix_last !== prev_last))
            stall_err = stall_err + 1;
        prev_stall = pix_valid && !pix_ready;
        prev_data  = pix_data;
        prev_last  = pix_last;
        if (pix_valid && pix_ready) begin
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            final_beat_cyc = cyc;
            if (pix_last) begin last_cnt = last_cnt + 1; last_idx = beats; end
            data_q.push_back(int'(pix_data));
            beats = beats + 1;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = int'(busy); end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " ram_rd_en"}, int'(ram_rd_en), 0);
        check({tag, " ram_rd_addr"}, int'(ram_rd_addr), 0);
        check({tag, " pix_valid"}, int'(pix_valid), 0);
        check({tag, " pix_data"}, int'(pix_data), 0);
        check({tag, " pix_last"}, int'(pix_last), 0);
    endtask

    typedef struct {
        int base;
        int src;
        int olen;
        int stp;
        int mode;        // 0: ready always high, 1: toggle with a 20-cycle stall
        int restart_at;  // cycle of an extra start pulse while busy, -1 for none
        int exp_addr[16];
    } vec_t;

    vec_t  vecs[NV];
    string vname[NV];

    function automatic logic ready_at(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (c >= 3 && c < 23) return 1'b0;
        return (c % 2) == 0;
    endfunction

    task automatic run_line(input int v);
        int n;
        clear_mon();
        n = vecs[v].olen;
        base_addr = AW'(vecs[v].base);
        src_len   = (AW+1)'(vecs[v].src);
        out_len   = (AW+1)'(n);
        step      = (SF+4)'(vecs[v].stp);
        start     = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (c > 0) begin
                if (c == vecs[v].restart_at) begin
                    start = 1'b1; base_addr = 12'd100; out_len = 13'd8;
                end else begin
                    start = 1'b0;
                end
            end
            pix_ready = ready_at(vecs[v].mode, c);
            @(posedge clk); #1;
            if (done_cyc >= 0) break;
        end
        start = 1'b0;
        pix_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check({vname[v], " done count"}, done_cnt, 1);
        check({vname[v], " reads issued"}, issues, n);
        check({vname[v], " beats"}, beats, n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s addr[%0d]", vname[v], i),
                  (i < addr_q.size()) ? addr_q[i] : -1, vecs[v].exp_addr[i]);
            check($sformatf("%s pixel[%0d]", vname[v], i),
                  (i < data_q.size()) ? data_q[i] : -1, 255 - (vecs[v].exp_addr[i] % 256));
        end
        check({vname[v], " last count"}, last_cnt, 1);
        check({vname[v], " last index"}, last_idx, n - 1);
        check({vname[v], " done after last"}, done_cyc - final_beat_cyc, 1);
        check({vname[v], " busy at first read"}, busy_at_en, 1);
        check({vname[v], " busy at done"}, busy_at_done, 0);
        check({vname[v], " stall stability"}, stall_err, 0);
        check({vname[v], " credit overflow"}, credit_err, 0);
        if (vecs[v].mode == 0) begin
            check({vname[v], " start to read"}, first_en_cyc - start_cyc, 1);
            check({vname[v], " read to valid"}, first_valid_cyc - first_en_cyc, LAT);
            check({vname[v], " throughput"}, final_beat_cyc - first_beat_cyc, n - 1);
        end
        $display("[TB] line %s: %0d reads, %0d beats, done at +%0d", vname[v], issues, beats,
                 done_cyc - start_cyc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vname[0] = "unity";
        vecs[0]  = '{0, 16, 16, 'h100, 0, -1, '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15}};
        vname[1] = "upscale2x";
        vecs[1]  = '{0, 8, 16, 'h080, 0, -1, '{0,0,1,1,2,2,3,3,4,4,5,5,6,6,7,7}};
        vname[2] = "downscale_clamp";
        vecs[2]  = '{0, 10, 5, 'h300, 0, -1, '{0,3,6,9,9,0,0,0,0,0,0,0,0,0,0,0}};
        vname[3] = "wrap_backpressure";
        vecs[3]  = '{4094, 4, 4, 'h100, 1, -1, '{4094,4095,0,1,0,0,0,0,0,0,0,0,0,0,0,0}};
        vname[4] = "start_while_busy";
        vecs[4]  = '{0, 16, 4, 'h100, 0, 2, '{0,1,2,3,0,0,0,0,0,0,0,0,0,0,0,0}};
        vname[5] = "step_zero";
        vecs[5]  = '{7, 5, 3, 'h000, 0, -1, '{7,7,7,0,0,0,0,0,0,0,0,0,0,0,0,0}};

        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset("after reset");
        $display("[TB] reset released");

        for (int v = 0; v < NV; v++) run_line(v);

        // Empty line: done without any pixel.
        clear_mon();
        out_len = '0; src_len = 13'd4; base_addr = 12'd5; step = 12'h100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 20 && done_cyc < 0; c++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("empty done delay", done_cyc - start_cyc, 2);
        check("empty done count", done_cnt, 1);
        check("empty pix_valid", valid_cnt, 0);
        check("empty reads", issues, 0);
        $display("[TB] line empty: done at +%0d", done_cyc - start_cyc);

        // Reset in the middle of a stalled line.
        clear_mon();
        base_addr = '0; src_len = 13'd16; out_len = 13'd16; step = 12'h100;
        pix_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midline busy before reset", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset("midline reset");
        clear_mon();
        pix_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("midline no done", done_cnt, 0);
        check("midline no beats", beats, 0);
        check("midline no reads", issues, 0);
        $display("[TB] line midline_reset: dropped");

        run_line(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
